// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART transmit engine and its FIFO.
//   tx_state_e : transmit FSM state encoding
//   FIFO_DEPTH : number of FIFO entries (16)
//   PTR_W      : FIFO pointer width; one extra bit so full and empty differ
//   DATA_W     : FIFO entry / shift register width
//   MIN_DATA / MAX_DATA : legal data-bits-per-frame range
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } tx_state_e;

  localparam int FIFO_DEPTH = 16;
  localparam int PTR_W      = 5;
  localparam int DATA_W     = 8;
  localparam int MIN_DATA   = 5;
  localparam int MAX_DATA   = 8;

  // True when the requested data length is one the engine supports.
  function automatic logic len_legal(input logic [3:0] n);
    return (n >= 4'(MIN_DATA)) && (n <= 4'(MAX_DATA));
  endfunction

  // Unsupported lengths fall back to a full byte.
  function automatic logic [3:0] eff_len(input logic [3:0] n);
    return len_legal(n) ? n : 4'(MAX_DATA);
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// -----------------------------------------------------------------------------
// tx_fifo
// 16 x 8 transmit FIFO with wrapping 5-bit read/write pointers. Occupancy is
// the pointer difference, so 16 (full) and 0 (empty) are distinguishable.
// A push while full is accepted only if a pop happens in the same cycle;
// otherwise it is dropped and o_overflow flags it for that cycle.
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_push, i_data     push strobe and byte
//   i_pop              pop strobe (ignored when empty)
//   o_data             current head byte (valid when !o_empty)
//   o_full, o_empty    status flags
//   o_count            occupancy 0..16
//   o_overflow         push dropped this cycle
// -----------------------------------------------------------------------------
module tx_fifo
  import uart_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [PTR_W-1:0]  o_count,
  output logic              o_overflow
);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_count    = r_wr_ptr - r_rd_ptr;
  assign o_full     = (o_count == PTR_W'(FIFO_DEPTH));
  assign o_empty    = (o_count == '0);
  assign w_do_pop   = i_pop && !o_empty;
  // When full, the slot being written is the one being read out this cycle;
  // the read is combinational so the head byte is taken before it is replaced.
  assign w_do_push  = i_push && (!o_full || w_do_pop);
  assign o_overflow = i_push && o_full && !w_do_pop;
  assign o_data     = r_mem[r_rd_ptr[PTR_W-2:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[PTR_W-2:0]] <= i_data;
  end

endmodule

// File: rtl/uart_tx_engine.sv
// -----------------------------------------------------------------------------
// uart_tx_engine
// UART transmitter: a 16-byte FIFO feeding a frame FSM
// (START, DATA x N, optional PARITY, STOP1, optional STOP2).
// Frame format is latched when a byte is popped, so format inputs may change
// freely while a frame is on the line.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   baud_tick           one-cycle pulse per bit period; all FSM moves use it
//   TXen                allow new frames to start (a running frame completes)
//   wr_en_i, wr_data_i  FIFO push
//   number_data_send    data bits per frame (5..8; others treated as 8 + error)
//   parity_bit_mode     append parity bit
//   parity_odd_i        1 = odd parity, 0 = even
//   stop_bit_twice      two stop bits
//   err_clr_i           clear sticky error (a same-cycle new error wins)
//   UART_TXD            registered serial line, idle high
//   tx_busy             FSM not in IDLE
//   TXdone              one-cycle pulse as the last stop bit ends
//   fifo_full, fifo_empty, fifo_count   FIFO status
//   error_tx_detect     sticky: FIFO overflow or illegal data length
// The FSM state is held in r_state (type tx_state_e) for probing.
// -----------------------------------------------------------------------------
module uart_tx_engine
  import uart_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              baud_tick,
  input  logic              TXen,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [3:0]        number_data_send,
  input  logic              parity_bit_mode,
  input  logic              parity_odd_i,
  input  logic              stop_bit_twice,
  input  logic              err_clr_i,
  output logic              UART_TXD,
  output logic              tx_busy,
  output logic              TXdone,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic [PTR_W-1:0]  fifo_count,
  output logic              error_tx_detect
);

  // FSM state
  tx_state_e r_state;
  tx_state_e w_state_next;

  // Frame datapath
  logic [DATA_W-1:0] r_shift;    // remaining data bits, next bit at [0]
  logic [2:0]        r_bit_cnt;  // index of data bit currently on the line
  logic [2:0]        r_last;     // index of final data bit for this frame
  logic              r_parity;   // XOR of data bits sent so far
  logic              r_par_en;
  logic              r_par_odd;
  logic              r_stop2;
  logic              r_txd;
  logic              r_done;
  logic              r_err;

  // Control strobes from the FSM
  logic              w_can_launch;
  logic              w_launch;     // pop FIFO head, latch frame format
  logic              w_data_step;  // put next data bit on the line
  logic              w_frame_end;  // leaving the final stop bit
  logic              w_txd_next;

  // FIFO interface and error sources
  logic [DATA_W-1:0] w_fifo_data;
  logic              w_overflow;
  logic [3:0]        w_len_eff;
  logic              w_new_err;

  tx_fifo u_fifo (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_push     (wr_en_i),
    .i_data     (wr_data_i),
    .i_pop      (w_launch),
    .o_data     (w_fifo_data),
    .o_full     (fifo_full),
    .o_empty    (fifo_empty),
    .o_count    (fifo_count),
    .o_overflow (w_overflow)
  );

  assign w_can_launch = TXen && !fifo_empty;
  assign w_len_eff    = eff_len(number_data_send);
  assign w_new_err    = w_overflow || (w_launch && !len_legal(number_data_send));

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // ---------------------------------------------------------------------------
  // Next state and line level. The line value computed here is registered,
  // so each bit appears the cycle after the tick that selects it and holds
  // for exactly one tick period.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_launch     = 1'b0;
    w_data_step  = 1'b0;
    w_frame_end  = 1'b0;
    w_txd_next   = r_txd;

    if (baud_tick) begin
      case (r_state)
        IDLE: begin
          if (w_can_launch) begin
            w_state_next = START;
            w_launch     = 1'b1;
            w_txd_next   = 1'b0;
          end
        end
        START: begin
          w_state_next = DATA;
          w_data_step  = 1'b1;
          w_txd_next   = r_shift[0];
        end
        DATA: begin
          if (r_bit_cnt == r_last) begin
            if (r_par_en) begin
              w_state_next = PARITY;
              w_txd_next   = r_parity ^ r_par_odd;
            end else begin
              w_state_next = STOP1;
              w_txd_next   = 1'b1;
            end
          end else begin
            w_data_step = 1'b1;
            w_txd_next  = r_shift[0];
          end
        end
        PARITY: begin
          w_state_next = STOP1;
          w_txd_next   = 1'b1;
        end
        STOP1: begin
          if (r_stop2) begin
            w_state_next = STOP2;
            w_txd_next   = 1'b1;
          end else begin
            w_frame_end = 1'b1;
          end
        end
        STOP2: begin
          w_frame_end = 1'b1;
        end
        default: begin
          w_state_next = IDLE;
          w_txd_next   = 1'b1;
        end
      endcase

      // Final stop bit ends: start the next frame on this same tick if one
      // is waiting, so back-to-back frames have no idle bit between them.
      if (w_frame_end) begin
        if (w_can_launch) begin
          w_state_next = START;
          w_launch     = 1'b1;
          w_txd_next   = 1'b0;
        end else begin
          w_state_next = IDLE;
          w_txd_next   = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: shift register, bit counter, parity accumulator, latched format
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_last    <= 3'd7;
      r_parity  <= 1'b0;
      r_par_en  <= 1'b0;
      r_par_odd <= 1'b0;
      r_stop2   <= 1'b0;
    end else if (w_launch) begin
      r_shift   <= w_fifo_data;
      r_bit_cnt <= '0;
      r_last    <= 3'(w_len_eff - 4'd1);
      r_parity  <= 1'b0;
      r_par_en  <= parity_bit_mode;
      r_par_odd <= parity_odd_i;
      r_stop2   <= stop_bit_twice;
    end else if (w_data_step) begin
      r_shift  <= {1'b0, r_shift[DATA_W-1:1]};
      r_parity <= r_parity ^ r_shift[0];
      // The START->DATA step emits bit 0; only later steps advance the index.
      if (r_state == DATA) r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Line, done pulse and sticky error
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_txd  <= 1'b1;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_txd  <= w_txd_next;
      r_done <= w_frame_end;
      if (w_new_err)      r_err <= 1'b1;
      else if (err_clr_i) r_err <= 1'b0;
    end
  end

  assign UART_TXD        = r_txd;
  assign TXdone          = r_done;
  assign tx_busy         = (r_state != IDLE);
  assign error_tx_detect = r_err;

endmodule

// File: tb/tb_uart_tx_engine.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_engine
// Directed bench for uart_tx_engine. Each pushed byte's expected serial frame
// (start, data LSB first, optional parity, stop bits) is built by a small
// model and queued; a line receiver samples UART_TXD mid-bit and compares
// each completed frame against the queue head.
// -----------------------------------------------------------------------------
module tb_uart_tx_engine;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       baud_tick = 1'b0;
  logic       TXen = 1'b0;
  logic       wr_en_i = 1'b0;
  logic [7:0] wr_data_i = 8'h00;
  logic [3:0] number_data_send = 4'd8;
  logic       parity_bit_mode = 1'b0;
  logic       parity_odd_i = 1'b0;
  logic       stop_bit_twice = 1'b0;
  logic       err_clr_i = 1'b0;
  logic       UART_TXD;
  logic       tx_busy;
  logic       TXdone;
  logic       fifo_full;
  logic       fifo_empty;
  logic [4:0] fifo_count;
  logic       error_tx_detect;

  uart_tx_engine dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .baud_tick        (baud_tick),
    .TXen             (TXen),
    .wr_en_i          (wr_en_i),
    .wr_data_i        (wr_data_i),
    .number_data_send (number_data_send),
    .parity_bit_mode  (parity_bit_mode),
    .parity_odd_i     (parity_odd_i),
    .stop_bit_twice   (stop_bit_twice),
    .err_clr_i        (err_clr_i),
    .UART_TXD         (UART_TXD),
    .tx_busy          (tx_busy),
    .TXdone           (TXdone),
    .fifo_full        (fifo_full),
    .fifo_empty       (fifo_empty),
    .fifo_count       (fifo_count),
    .error_tx_detect  (error_tx_detect)
  );

  // ---------------------------------------------------------------------------
  // Clock, cycle counter, baud tick every 16 cycles
  // ---------------------------------------------------------------------------
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int baud_cnt = 0;
  always @(negedge clk_i) begin
    baud_cnt  = (baud_cnt == 15) ? 0 : baud_cnt + 1;
    baud_tick = (baud_cnt == 15);
  end

  int done_cnt = 0;
  always @(negedge clk_i) if (TXdone === 1'b1) done_cnt = done_cnt + 1;

  // ---------------------------------------------------------------------------
  // Scoreboard state and frame model
  // ---------------------------------------------------------------------------
  logic [11:0] exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  int  cfg_len   = 8;
  bit  cfg_par   = 0;
  bit  cfg_odd   = 0;
  bit  cfg_stop2 = 0;

  bit  rx_en      = 1;
  bit  rx_active  = 0;
  bit  b2b_chk    = 0;
  bit  prev_valid = 0;
  int  prev_start = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Bit i of the result is the i-th bit on the line; unused upper bits are 0.
  function automatic logic [11:0] mk_frame(input logic [7:0] d, input int len,
                                           input bit par, input bit odd, input bit stop2);
    logic [11:0] f = '0;
    int  p = 1;
    logic pb = odd;
    for (int i = 0; i < len; i++) begin
      f[p] = d[i];
      pb   = pb ^ d[i];
      p++;
    end
    if (par) begin
      f[p] = pb;
      p++;
    end
    f[p] = 1'b1;
    p++;
    if (stop2) f[p] = 1'b1;
    return f;
  endfunction

  // ---------------------------------------------------------------------------
  // Line receiver: start bit detected on its first cycle, then sampled mid-bit
  // ---------------------------------------------------------------------------
  initial begin : rx_proc
    logic [11:0] obs;
    logic [11:0] exp;
    int nb;
    forever begin
      @(negedge clk_i);
      if (rx_en && UART_TXD === 1'b0) begin
        rx_active = 1;
        nb = 2 + cfg_len + int'(cfg_par) + int'(cfg_stop2);
        if (b2b_chk && prev_valid)
          check("b2b_gap", 32'(cyc - prev_start), 32'(16 * nb));
        prev_start = cyc;
        prev_valid = 1;
        obs = '0;
        repeat (8) @(negedge clk_i);
        obs[0] = UART_TXD;
        for (int i = 1; i < nb; i++) begin
          repeat (16) @(negedge clk_i);
          obs[i] = UART_TXD;
        end
        if (exp_q.size() == 0) begin
          check("rx_unexpected_frame", 32'(obs), 32'hFFFF_FFFF);
        end else begin
          exp = exp_q.pop_front();
          check("rx_frame", 32'(obs), 32'(exp));
        end
        rx_active = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic set_cfg(input logic [3:0] nds, input int len, input bit par,
                         input bit odd, input bit stop2);
    number_data_send = nds;
    parity_bit_mode  = par;
    parity_odd_i     = odd;
    stop_bit_twice   = stop2;
    cfg_len   = len;
    cfg_par   = par;
    cfg_odd   = odd;
    cfg_stop2 = stop2;
  endtask

  task automatic push(input logic [7:0] b, input bit expect_tx);
    @(negedge clk_i);
    wr_en_i   = 1'b1;
    wr_data_i = b;
    if (expect_tx) exp_q.push_back(mk_frame(b, cfg_len, cfg_par, cfg_odd, cfg_stop2));
    @(negedge clk_i);
    wr_en_i = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || rx_active || tx_busy) && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    check(tag, 32'(n < budget), 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin : main
    int d0;
    int n;
    logic [7:0] b;

    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst_txd",   32'(UART_TXD), 32'd1);
    check("rst_busy",  32'(tx_busy), 32'd0);
    check("rst_done",  32'(TXdone), 32'd0);
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_full",  32'(fifo_full), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_err",   32'(error_tx_detect), 32'd0);
    rst_i = 1'b0;

    // 8N1, 0xA5
    set_cfg(4'd8, 8, 0, 0, 0);
    TXen = 1'b1;
    d0 = done_cnt;
    push(8'hA5, 1);
    wait_drain("drain_8n1", 400);
    repeat (2) @(negedge clk_i);
    check("8n1_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("8n1_txd_idle", 32'(UART_TXD), 32'd1);

    // 7 data bits, even parity, two stop bits, 0x41
    set_cfg(4'd7, 7, 1, 0, 1);
    push(8'h41, 1);
    wait_drain("drain_7e2", 400);

    // 8 data bits, odd parity, 0x03
    set_cfg(4'd8, 8, 1, 1, 0);
    push(8'h03, 1);
    wait_drain("drain_8o1", 400);

    // 5 data bits, even parity: upper bits of the byte are not sent
    set_cfg(4'd5, 5, 1, 0, 0);
    push(8'hF6, 1);
    wait_drain("drain_5e1", 400);
    check("5e1_err", 32'(error_tx_detect), 32'd0);

    // Illegal length 3 behaves as 8 and raises the error flag
    set_cfg(4'd3, 8, 0, 0, 0);
    push(8'h96, 1);
    wait_drain("drain_len3", 400);
    check("len3_err", 32'(error_tx_detect), 32'd1);
    @(negedge clk_i);
    err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
    check("len3_err_clr", 32'(error_tx_detect), 32'd0);

    // Overflow: 17 pushes with TXen low, 17th dropped
    set_cfg(4'd8, 8, 0, 0, 0);
    TXen = 1'b0;
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom_range(0, 255));
      push(b, i < 16);
    end
    check("ovf_count", 32'(fifo_count), 32'd16);
    check("ovf_full",  32'(fifo_full), 32'd1);
    check("ovf_err",   32'(error_tx_detect), 32'd1);
    // Clear and new overflow in the same cycle: error stays set
    @(negedge clk_i);
    err_clr_i = 1'b1;
    wr_en_i   = 1'b1;
    wr_data_i = 8'hEE;
    @(negedge clk_i);
    err_clr_i = 1'b0;
    wr_en_i   = 1'b0;
    check("err_new_wins", 32'(error_tx_detect), 32'd1);
    check("ovf_count_held", 32'(fifo_count), 32'd16);
    err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
    check("err_clr", 32'(error_tx_detect), 32'd0);
    b2b_chk    = 1;
    prev_valid = 0;
    TXen = 1'b1;
    wait_drain("drain_ovf16", 3500);
    b2b_chk = 0;
    check("ovf_empty_after", 32'(fifo_empty), 32'd1);

    // Reset during data bit 3
    rx_en = 0;
    push(8'h00, 0);
    push(8'h00, 0);
    n = 0;
    while (UART_TXD !== 1'b0 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check("rstmid_start_seen", 32'(n < 200), 32'd1);
    repeat (16 * 4 + 8) @(negedge clk_i);
    check("rstmid_pre_count", 32'(fifo_count), 32'd1);
    rst_i = 1'b1;
    TXen  = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("rstmid_txd",   32'(UART_TXD), 32'd1);
    check("rstmid_count", 32'(fifo_count), 32'd0);
    check("rstmid_busy",  32'(tx_busy), 32'd0);
    check("rstmid_empty", 32'(fifo_empty), 32'd1);
    rx_en = 1;
    TXen  = 1'b1;
    push(8'h55, 1);
    wait_drain("drain_after_rst", 400);

    // Push and pop in the same cycle at count 16
    TXen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom_range(0, 255));
      push(b, 1);
    end
    check("pp_pre_count", 32'(fifo_count), 32'd16);
    n = 0;
    do begin
      @(negedge clk_i);
      #1;
      n++;
    end while (!baud_tick && n < 40);
    wr_en_i   = 1'b1;
    wr_data_i = 8'h3C;
    TXen      = 1'b1;
    exp_q.push_back(mk_frame(8'h3C, cfg_len, cfg_par, cfg_odd, cfg_stop2));
    @(negedge clk_i);
    #1;
    wr_en_i = 1'b0;
    check("pp_count", 32'(fifo_count), 32'd16);
    check("pp_err",   32'(error_tx_detect), 32'd0);
    check("pp_busy",  32'(tx_busy), 32'd1);
    b2b_chk    = 1;
    prev_valid = 0;
    wait_drain("drain_pp17", 3500);
    b2b_chk = 0;
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
